// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared constants and FSM state type
// for the instruction-fetch stage and its fetch queue.
package if_fetch_unit_pkg;

  localparam int PC_STEP = 4;

  localparam logic [31:0] NOP_INSTR = 32'h0;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit_fifo.sv
// fetch_fifo: in-order {pc, instr} queue, DEPTH x W, with clear.
// Ports: i_push/i_wdata, i_pop, i_clear, o_head, o_count, o_empty.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 96
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic                   i_push,
  input  logic [W-1:0]           i_wdata,
  input  logic                   i_pop,
  input  logic                   i_clear,
  output logic [W-1:0]           o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic          w_pop;
  logic          w_push;

  // push while full is only taken together with a pop
  assign w_pop  = i_pop && (r_cnt != '0);
  assign w_push = i_push &&
                  ((r_cnt != (AW+1)'(DEPTH)) || w_pop);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (i_clear) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_push)
                     - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_clear) r_mem[r_wp] <= i_wdata;
  end

  assign o_head  = r_mem[r_rp];
  assign o_count = r_cnt;
  assign o_empty = (r_cnt == '0);

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: fetch PC, pipelined imem reads (<=2 in flight),
// fetch queue toward IF/ID, redirect flush with stale-response drain.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] PC_RESET = '0,
  parameter int                DEPTH    = 4
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              id_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_instr,
  output logic              if_flush
);

  localparam int EW = ADDR_W + DATA_W;
  localparam int CW = $clog2(DEPTH) + 2;

  fetch_state_e          r_state;
  logic [ADDR_W-1:0]     r_pc;
  logic [1:0]            r_out;
  logic [1:0]            r_discard;

  logic [$clog2(DEPTH):0] w_count;
  logic [EW-1:0]         w_head;
  logic                  w_empty;
  logic                  w_room;
  logic                  w_issue;
  logic                  w_push;
  logic                  w_pop;
  logic [1:0]            w_left;
  logic [ADDR_W-1:0]     w_rsp_pc;

  // queue slots already promised to in-flight reads count as used
  assign w_room  = (CW'(w_count) + CW'(r_out)) < CW'(DEPTH);
  assign w_issue = (r_state == RUN) && (r_out < 2'd2) &&
                   w_room && !redirect_valid;
  assign w_push  = imem_rvalid && (r_state == RUN) &&
                   !redirect_valid;
  assign w_pop   = !w_empty && id_ready;
  assign w_left  = r_out - 2'(imem_rvalid);

  // in RUN the live requests are consecutive and end at r_pc-4,
  // so the oldest one sits r_out steps behind r_pc
  assign w_rsp_pc = r_pc - (ADDR_W'(r_out) << 2);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state   <= BOOT;
      r_pc      <= PC_RESET;
      r_out     <= 2'd0;
      r_discard <= 2'd0;
    end else begin
      r_out <= r_out + 2'(w_issue) - 2'(imem_rvalid);
      if (redirect_valid) begin
        r_pc      <= redirect_pc & ~ADDR_W'(3);
        r_discard <= w_left;
        r_state   <= (w_left != 2'd0) ? DRAIN : RUN;
      end else begin
        case (r_state)
          BOOT: r_state <= RUN;
          RUN: begin
            if (w_issue) r_pc <= r_pc + ADDR_W'(PC_STEP);
          end
          DRAIN: begin
            if (imem_rvalid) begin
              r_discard <= r_discard - 2'd1;
              if (r_discard == 2'd1) r_state <= RUN;
            end
          end
          default: r_state <= BOOT;
        endcase
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk     (clk),
    .arst_n  (arst_n),
    .i_push  (w_push),
    .i_wdata ({w_rsp_pc, imem_rdata}),
    .i_pop   (w_pop),
    .i_clear (redirect_valid),
    .o_head  (w_head),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  assign imem_req  = w_issue;
  assign imem_addr = r_pc;
  assign if_flush  = redirect_valid;
  assign if_valid  = !w_empty;
  assign if_pc     = w_empty ? '0 : w_head[EW-1:DATA_W];
  assign if_instr  = w_empty ? DATA_W'(NOP_INSTR)
                             : w_head[DATA_W-1:0];

endmodule
